alu_pin_stimulus_driver: RTL

//  Driver end of the tt_um 4-bit ALU pin interface: generates pseudo-random operand/opcode vectors on
//  ui_in/uio_in-shaped outputs, samples the ALU's uo_out, and checks it against a built-in reference model.

---
 rtl/alu_pin_pkg.sv | 25 ++
 rtl/alu_ref_model.sv | 32 +++
 rtl/alu_pin_stimulus_driver.sv | 137 +++++++++++++
 3 files changed

// File: rtl/alu_pin_pkg.sv
// Shared constants for the 4-bit ALU pin-interface stimulus driver:
// opcode encodings, sequencer state encoding and the LFSR/MISR feedback taps.
package alu_pin_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_NOT = 3'd7;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_FINISH
    } state_t;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational reference for the 4-bit tt_um ALU: (a, b, op) -> expected uo_out.
module alu_ref_model
    import alu_pin_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] op,
    output logic [7:0] expected
);

    logic [4:0] sum;
    logic [4:0] diff;

    always_comb begin
        sum      = {1'b0, a} + {1'b0, b};
        // Bit 4 of the 5-bit difference is the borrow out of the nibble subtract
        diff     = {1'b0, a} - {1'b0, b};
        expected = 8'h00;
        case (op)
            OP_ADD:  expected = {3'b000, sum};
            OP_SUB:  expected = {3'b000, diff};
            OP_MUL:  expected = {4'b0000, a} * {4'b0000, b};
            OP_DIV:  expected = (b == 4'd0) ? 8'hFF : {a / b, a % b};
            OP_AND:  expected = {4'b0000, a & b};
            OP_OR:   expected = {4'b0000, a | b};
            OP_XOR:  expected = {4'b0000, a ^ b};
            OP_NOT:  expected = {4'b0000, ~a};
            default: expected = 8'h00;
        endcase
    end

endmodule

// File: rtl/alu_pin_stimulus_driver.sv
// Self-test sequencer for the 4-bit ALU pins: LFSR vectors out, uo_out checked against alu_ref_model.
// Define ALU_PIN_DRV_MISR_EN to build the response-compaction MISR behind the signature output.
module alu_pin_stimulus_driver
    import alu_pin_pkg::*;
#(
    parameter int          NUM_VECTORS   = 256,
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  fail_count,
    output logic [15:0] first_fail,
    output logic [7:0]  drv_ui,
    output logic [7:0]  drv_uio,
    input  logic [7:0]  dut_uo,
    output logic [15:0] signature
);

    localparam logic [15:0] LAST_IDX    = 16'(NUM_VECTORS - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 2);
    localparam logic [15:0] NO_FAIL     = 16'hFFFF;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t      state;
    state_t      state_next;
    logic [15:0] lfsr;
    logic [15:0] index;
    logic [15:0] settle_cnt;
    logic [7:0]  expected;
    logic        mismatch;
    logic        accept;

    alu_ref_model u_ref (
        .a        (drv_ui[7:4]),
        .b        (drv_ui[3:0]),
        .op       (drv_uio[2:0]),
        .expected (expected)
    );

    assign mismatch = (dut_uo != expected);
    assign accept   = (state == ST_IDLE) && start;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_DRIVE;
            ST_DRIVE:  state_next = (SETTLE_CYCLES > 1) ? ST_SETTLE : ST_CHECK;
            ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_next = ST_CHECK;
            ST_CHECK:  state_next = (index == LAST_IDX) ? ST_FINISH : ST_DRIVE;
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_count <= 8'h00;
            first_fail <= NO_FAIL;
            drv_ui     <= 8'h00;
            drv_uio    <= 8'h00;
            lfsr       <= LFSR_SEED;
            index      <= 16'h0000;
            settle_cnt <= 16'h0000;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        lfsr       <= LFSR_SEED;
                        index      <= 16'h0000;
                        fail_count <= 8'h00;
                        first_fail <= NO_FAIL;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    drv_ui     <= {lfsr[15:12], lfsr[11:8]};
                    drv_uio    <= {5'b00000, lfsr[2:0]};
                    settle_cnt <= 16'h0000;
                end
                ST_SETTLE: settle_cnt <= settle_cnt + 16'd1;
                ST_CHECK: begin
                    if (mismatch) begin
                        fail_count <= sat_inc(fail_count);
                        if (first_fail == NO_FAIL) first_fail <= index;
                    end
                    lfsr  <= lfsr_next(lfsr);
                    index <= index + 16'd1;
                end
                ST_FINISH: begin
                    // busy falls on the same edge that raises the done pulse
                    pass <= (fail_count == 8'h00);
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_PIN_DRV_MISR_EN
    logic [15:0] misr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misr <= 16'h0000;
        end else if (accept) begin
            misr <= 16'h0000;
        end else if (state == ST_CHECK) begin
            misr <= lfsr_next(misr) ^ {8'h00, dut_uo};
        end
    end

    assign signature = misr;
`else
    assign signature = 16'h0000;
`endif

endmodule
